// File: rtl/ahb_slave_if_param.sv
// ---------------------------------------------------------------------------
// ahb_slave_if_param
//
// Purpose:
//   AHB slave front-end for the AHB-to-APB bridge. It decodes NUM_SLV
//   contiguous, equal-size APB regions into a one-hot select. It pipelines
//   the address, write data and direction for the bridge FSM. It also
//   answers unmapped, misaligned or oversize transfers itself with the
//   two-cycle AHB ERROR response.
//
// Ports:
//   Hclk, Hreset        clock, asynchronous active-high reset
//   Hwrite, Hreadyin    transfer direction, bus-wide HREADY
//   Htrans, Hsize       transfer type (IDLE/BUSY/NONSEQ/SEQ), transfer size
//   Haddr, Hwdata       address phase address, data phase write data
//   Prdata              read data returned by the bridge
//   bridge_ready        bridge can accept/complete a transfer
//   valid               legal mapped transfer in this address phase
//   tempselx            one-hot region select (combinational)
//   Haddr1, Haddr2      address pipeline stages
//   Hwdata1, Hwdata2    write-data pipeline stages
//   Hwritereg           registered Hwrite
//   Hrdata              read data to master
//   Hreadyout, Hresp    slave HREADY and response (OKAY=00, ERROR=01)
//
// Note: the alignment check looks at Haddr[7:0], so ADDR_W must be >= 8.
// ---------------------------------------------------------------------------
module ahb_slave_if_param #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_SLV     = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] REGION_SIZE = 32'h0400_0000
) (
    input  logic               Hclk,
    input  logic               Hreset,
    input  logic               Hwrite,
    input  logic               Hreadyin,
    input  logic [1:0]         Htrans,
    input  logic [2:0]         Hsize,
    input  logic [ADDR_W-1:0]  Haddr,
    input  logic [DATA_W-1:0]  Hwdata,
    input  logic [DATA_W-1:0]  Prdata,
    input  logic               bridge_ready,
    output logic               valid,
    output logic [NUM_SLV-1:0] tempselx,
    output logic [ADDR_W-1:0]  Haddr1,
    output logic [ADDR_W-1:0]  Haddr2,
    output logic [DATA_W-1:0]  Hwdata1,
    output logic [DATA_W-1:0]  Hwdata2,
    output logic               Hwritereg,
    output logic [DATA_W-1:0]  Hrdata,
    output logic               Hreadyout,
    output logic [1:0]         Hresp
);

    // Largest legal Hsize: log2 of the bus width in bytes.
    localparam int SIZE_MAX    = $clog2(DATA_W / 8);
    localparam int REGION_LOG2 = $clog2(REGION_SIZE);

    // Bounds are held one bit wider than the address so that a window
    // ending exactly at 2^ADDR_W does not wrap to zero.
    localparam logic [ADDR_W:0] BASE_EXT = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] END_EXT  =
        BASE_EXT + (ADDR_W + 1)'(NUM_SLV) * {1'b0, REGION_SIZE};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] haddr1_q, haddr1_d;
    logic [ADDR_W-1:0] haddr2_q, haddr2_d;
    logic [DATA_W-1:0] hwdata1_q, hwdata1_d;
    logic [DATA_W-1:0] hwdata2_q, hwdata2_d;
    logic              hwrite_q, hwrite_d;

    logic [ADDR_W:0]   addr_ext;
    logic [ADDR_W:0]   offset;
    logic [ADDR_W:0]   region_idx;
    logic [7:0]        size_mask;
    logic              mapped;
    logic              aligned;
    logic              size_ok;
    logic              legal;
    logic              active;
    logic [NUM_SLV-1:0] sel;

    // Htrans[0] only separates BUSY from IDLE and NONSEQ from SEQ. Neither
    // distinction matters here, so the bit is deliberately left unused.
    logic unused_trans_lsb;
    assign unused_trans_lsb = Htrans[0];

    // Address decode and legality of the current address phase.
    always_comb begin
        addr_ext   = {1'b0, Haddr};
        mapped     = (addr_ext >= BASE_EXT) && (addr_ext < END_EXT);
        offset     = addr_ext - BASE_EXT;
        region_idx = offset >> REGION_LOG2;
        sel        = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (mapped && (region_idx == (ADDR_W + 1)'(k))) begin
                sel[k] = 1'b1;
            end
        end
        size_mask = 8'((9'd1 << Hsize) - 9'd1);
        aligned   = (Haddr[7:0] & size_mask) == 8'd0;
        size_ok   = Hsize <= 3'(SIZE_MAX);
        legal     = mapped && aligned && size_ok;
        active    = Hreadyin && Htrans[1];
    end

    // Error FSM: an illegal active transfer seen in IDLE starts the
    // two-cycle ERROR response. Transfers seen during ERR2 are dropped,
    // because the master cancels them after an ERROR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (active && !legal) state_d = ST_ERR1;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The pipeline advances only while the bus is ready. Write data comes
    // one cycle after its address, so Hwdata1 lines up with Haddr2.
    always_comb begin
        haddr1_d  = haddr1_q;
        haddr2_d  = haddr2_q;
        hwdata1_d = hwdata1_q;
        hwdata2_d = hwdata2_q;
        hwrite_d  = hwrite_q;
        if (Hreadyin) begin
            haddr1_d  = Haddr;
            haddr2_d  = haddr1_q;
            hwdata1_d = Hwdata;
            hwdata2_d = hwdata1_q;
            hwrite_d  = Hwrite;
        end
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q   <= ST_IDLE;
            haddr1_q  <= '0;
            haddr2_q  <= '0;
            hwdata1_q <= '0;
            hwdata2_q <= '0;
            hwrite_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            haddr1_q  <= haddr1_d;
            haddr2_q  <= haddr2_d;
            hwdata1_q <= hwdata1_d;
            hwdata2_q <= hwdata2_d;
            hwrite_q  <= hwrite_d;
        end
    end

    assign valid     = active && legal && (state_q == ST_IDLE);
    assign tempselx  = sel;
    assign Haddr1    = haddr1_q;
    assign Haddr2    = haddr2_q;
    assign Hwdata1   = hwdata1_q;
    assign Hwdata2   = hwdata2_q;
    assign Hwritereg = hwrite_q;
    assign Hrdata    = (state_q == ST_IDLE) ? Prdata : '0;
    assign Hreadyout = (state_q == ST_ERR1) ? 1'b0 :
                       (state_q == ST_ERR2) ? 1'b1 : bridge_ready;
    assign Hresp     = (state_q == ST_IDLE) ? 2'b00 : 2'b01;

endmodule

// File: tb/tb_ahb_slave_if_param.sv
module tb_ahb_slave_if_param;

    logic        Hclk = 1'b0;
    logic        Hreset;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [2:0]  Hsize;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Prdata;
    logic        bridge_ready;

    logic        valid;
    logic [2:0]  tempselx;
    logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2, Hrdata;
    logic        Hwritereg, Hreadyout;
    logic [1:0]  Hresp;

    logic        valid8;
    logic [7:0]  tempselx8;
    logic [31:0] haddr1_8, haddr2_8, hwdata1_8, hwdata2_8, hrdata_8;
    logic        hwritereg_8, hreadyout_8;
    logic [1:0]  hresp_8;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: error cycles still to be shown (2 = ready-low
    // ERROR cycle, 1 = ready-high ERROR cycle) and the pipeline contents.
    int          m_err;
    logic [31:0] m_a1, m_a2, m_w1, m_w2;
    logic        m_wr;

    always #5 Hclk = ~Hclk;

    ahb_slave_if_param dut (
        .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
        .Htrans(Htrans), .Hsize(Hsize), .Haddr(Haddr), .Hwdata(Hwdata),
        .Prdata(Prdata), .bridge_ready(bridge_ready), .valid(valid),
        .tempselx(tempselx), .Haddr1(Haddr1), .Haddr2(Haddr2),
        .Hwdata1(Hwdata1), .Hwdata2(Hwdata2), .Hwritereg(Hwritereg),
        .Hrdata(Hrdata), .Hreadyout(Hreadyout), .Hresp(Hresp)
    );

    ahb_slave_if_param #(
        .NUM_SLV(8), .BASE_ADDR(32'hF000_0000), .REGION_SIZE(32'h0200_0000)
    ) dut8 (
        .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
        .Htrans(Htrans), .Hsize(Hsize), .Haddr(Haddr), .Hwdata(Hwdata),
        .Prdata(Prdata), .bridge_ready(bridge_ready), .valid(valid8),
        .tempselx(tempselx8), .Haddr1(haddr1_8), .Haddr2(haddr2_8),
        .Hwdata1(hwdata1_8), .Hwdata2(hwdata2_8), .Hwritereg(hwritereg_8),
        .Hrdata(hrdata_8), .Hreadyout(hreadyout_8), .Hresp(hresp_8)
    );

    // One-hot region select from plain interval arithmetic.
    function automatic longint model_sel(longint a, longint base, longint rsize, longint n);
        if (a >= base && a < base + n * rsize) return longint'(1) << ((a - base) / rsize);
        return 0;
    endfunction

    function automatic bit model_legal(longint a, int size, longint base, longint rsize, longint n);
        return (model_sel(a, base, rsize, n) != 0) && (size <= 2) && ((a % (longint'(1) << size)) == 0);
    endfunction

    task automatic model_reset();
        m_err = 0;
        m_a1 = '0; m_a2 = '0; m_w1 = '0; m_w2 = '0; m_wr = 1'b0;
    endtask

    // Advance one clock and update the model with what the bus showed.
    task automatic tick();
        @(posedge Hclk);
        if (Hreset) begin
            model_reset();
        end else begin
            if (m_err > 0) m_err--;
            else if (Hreadyin && Htrans[1] &&
                     !model_legal(Haddr, int'(Hsize), 64'h8000_0000, 64'h0400_0000, 3))
                m_err = 2;
            if (Hreadyin) begin
                m_a2 = m_a1; m_a1 = Haddr;
                m_w2 = m_w1; m_w1 = Hwdata;
                m_wr = Hwrite;
            end
        end
        #1;
    endtask

    task automatic set_bus(input logic [1:0] tr, input logic [2:0] sz, input logic [31:0] ad,
                           input logic wr, input logic [31:0] wd, input logic rdy);
        Htrans = tr; Hsize = sz; Haddr = ad; Hwrite = wr; Hwdata = wd; Hreadyin = rdy;
    endtask

    task automatic test_reset();
        Hreset = 1'b1; bridge_ready = 1'b1; Prdata = '0;
        set_bus(2'b00, 3'd0, 32'h0, 1'b0, 32'h0, 1'b1);
        #3;
        n_checks++;
        if (Hreadyout !== 1'b1 || Hresp !== 2'b00) begin
            n_fail++; $display("[TB] FAIL reset_resp: got ready=%b resp=%b expected 1/00", Hreadyout, Hresp);
        end
        n_checks++;
        if (Haddr1 !== 32'h0 || Haddr2 !== 32'h0 || Hwdata1 !== 32'h0 || Hwritereg !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_pipe: got a1=%h a2=%h w1=%h wr=%b expected zeros",
                               Haddr1, Haddr2, Hwdata1, Hwritereg);
        end
        tick(); tick();
        Hreset = 1'b0;
    endtask

    task automatic test_mapped_write();
        set_bus(2'b10, 3'd2, 32'h8400_0010, 1'b1, 32'h0, 1'b1);
        #2;
        n_checks++;
        if (valid !== 1'b1 || tempselx !== 3'b010) begin
            n_fail++; $display("[TB] FAIL write_decode: got valid=%b sel=%b expected 1/010", valid, tempselx);
        end
        tick();
        n_checks++;
        if (Haddr1 !== 32'h8400_0010 || Hwritereg !== 1'b1) begin
            n_fail++; $display("[TB] FAIL write_addr1: got a1=%h wr=%b expected 84000010/1", Haddr1, Hwritereg);
        end
        set_bus(2'b00, 3'd0, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        #2;
        tick();
        n_checks++;
        if (Hwdata1 !== 32'hDEAD_BEEF || Haddr2 !== 32'h8400_0010) begin
            n_fail++; $display("[TB] FAIL write_data: got w1=%h a2=%h expected deadbeef/84000010", Hwdata1, Haddr2);
        end
    endtask

    task automatic test_unmapped();
        Prdata = 32'h1234_5678;
        set_bus(2'b10, 3'd2, 32'h8C00_0000, 1'b0, 32'h0, 1'b1);
        #2;
        n_checks++;
        if (valid !== 1'b0 || tempselx !== 3'b000) begin
            n_fail++; $display("[TB] FAIL unmapped_decode: got valid=%b sel=%b expected 0/000", valid, tempselx);
        end
        tick();
        set_bus(2'b00, 3'd0, 32'h0, 1'b0, 32'h0, 1'b1);
        #2;
        n_checks++;
        if (Hreadyout !== 1'b0 || Hresp !== 2'b01 || Hrdata !== 32'h0) begin
            n_fail++; $display("[TB] FAIL unmapped_err1: got ready=%b resp=%b rdata=%h expected 0/01/0",
                               Hreadyout, Hresp, Hrdata);
        end
        tick();
        n_checks++;
        if (Hreadyout !== 1'b1 || Hresp !== 2'b01) begin
            n_fail++; $display("[TB] FAIL unmapped_err2: got ready=%b resp=%b expected 1/01", Hreadyout, Hresp);
        end
        tick();
        n_checks++;
        if (Hreadyout !== 1'b1 || Hresp !== 2'b00 || Hrdata !== 32'h1234_5678) begin
            n_fail++; $display("[TB] FAIL unmapped_idle: got ready=%b resp=%b rdata=%h expected 1/00/12345678",
                               Hreadyout, Hresp, Hrdata);
        end
    endtask

    task automatic test_misaligned_oversize();
        logic [31:0] addrs [2];
        logic [2:0]  sizes [2];
        addrs[0] = 32'h8000_0002; sizes[0] = 3'd2;
        addrs[1] = 32'h8000_0000; sizes[1] = 3'd3;
        for (int i = 0; i < 2; i++) begin
            set_bus(2'b10, sizes[i], addrs[i], 1'b1, 32'h0, 1'b1);
            #2;
            n_checks++;
            if (valid !== 1'b0 || tempselx !== 3'b001) begin
                n_fail++; $display("[TB] FAIL illegal_decode[%0d]: got valid=%b sel=%b expected 0/001", i, valid, tempselx);
            end
            tick();
            set_bus(2'b00, 3'd0, 32'h0, 1'b0, 32'h0, 1'b1);
            #2;
            n_checks++;
            if (Hreadyout !== 1'b0 || Hresp !== 2'b01) begin
                n_fail++; $display("[TB] FAIL illegal_err1[%0d]: got ready=%b resp=%b expected 0/01", i, Hreadyout, Hresp);
            end
            tick();
            n_checks++;
            if (Hreadyout !== 1'b1 || Hresp !== 2'b01) begin
                n_fail++; $display("[TB] FAIL illegal_err2[%0d]: got ready=%b resp=%b expected 1/01", i, Hreadyout, Hresp);
            end
            tick();
            n_checks++;
            if (Hresp !== 2'b00) begin
                n_fail++; $display("[TB] FAIL illegal_idle[%0d]: got resp=%b expected 00", i, Hresp);
            end
        end
    endtask

    task automatic test_wait_states();
        set_bus(2'b10, 3'd2, 32'h8000_0100, 1'b1, 32'hA5A5_0001, 1'b1);
        #2;
        tick();
        for (int i = 0; i < 3; i++) begin
            set_bus(2'b11, 3'd2, 32'h8000_0104 + 32'(i * 4), 1'b0, $urandom, 1'b0);
            #2;
            tick();
            n_checks++;
            if (Haddr1 !== 32'h8000_0100 || Hwdata1 !== 32'hA5A5_0001 || Hwritereg !== 1'b1) begin
                n_fail++; $display("[TB] FAIL wait_hold[%0d]: got a1=%h w1=%h wr=%b expected 80000100/a5a50001/1",
                                   i, Haddr1, Hwdata1, Hwritereg);
            end
        end
        set_bus(2'b01, 3'd2, 32'h8000_0200, 1'b0, 32'h0, 1'b1);
        #2;
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL busy_valid: got %b expected 0", valid);
        end
        tick();
        n_checks++;
        if (Hresp !== 2'b00 || Hreadyout !== 1'b1) begin
            n_fail++; $display("[TB] FAIL busy_noerr: got ready=%b resp=%b expected 1/00", Hreadyout, Hresp);
        end
    endtask

    task automatic test_param8();
        logic [31:0] addrs [5];
        logic [7:0]  exps  [5];
        addrs[0] = 32'hFE00_0000; exps[0] = 8'h80;
        addrs[1] = 32'hFFFF_FFFC; exps[1] = 8'h80;
        addrs[2] = 32'hF000_0000; exps[2] = 8'h01;
        addrs[3] = 32'hEFFF_FFFC; exps[3] = 8'h00;
        addrs[4] = 32'hF200_0000; exps[4] = 8'h02;
        set_bus(2'b00, 3'd0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            set_bus(2'b00, 3'd2, addrs[i], 1'b0, 32'h0, 1'b1);
            #2;
            n_checks++;
            if (tempselx8 !== exps[i]) begin
                n_fail++; $display("[TB] FAIL sel8[%0d]: addr=%h got %h expected %h", i, addrs[i], tempselx8, exps[i]);
            end
        end
        set_bus(2'b10, 3'd2, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
        #2;
        n_checks++;
        if (valid8 !== 1'b1) begin
            n_fail++; $display("[TB] FAIL valid8_top: got %b expected 1", valid8);
        end
        tick();
        set_bus(2'b00, 3'd0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid_err();
        set_bus(2'b10, 3'd2, 32'h8C00_0000, 1'b1, 32'h0, 1'b1);
        #2;
        tick();
        set_bus(2'b00, 3'd0, 32'h0, 1'b0, 32'h5555_AAAA, 1'b1);
        #2;
        n_checks++;
        if (Hresp !== 2'b01 || Hreadyout !== 1'b0) begin
            n_fail++; $display("[TB] FAIL pre_reset_err1: got ready=%b resp=%b expected 0/01", Hreadyout, Hresp);
        end
        Hreset = 1'b1;
        #1;
        n_checks++;
        if (Hreadyout !== 1'b1 || Hresp !== 2'b00 || Haddr1 !== 32'h0 || Hwritereg !== 1'b0) begin
            n_fail++; $display("[TB] FAIL async_reset: got ready=%b resp=%b a1=%h wr=%b expected 1/00/0/0",
                               Hreadyout, Hresp, Haddr1, Hwritereg);
        end
        tick();
        Hreset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic        exp_valid;
        logic [2:0]  exp_sel;
        logic [7:0]  exp_sel8;
        logic        exp_ready;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000 + ($urandom_range(0, 32'h0BFF_FFFF) & 32'hFFFF_FFFC);
                1: a = $urandom;
                2: a = 32'h8BFF_FFF0 + $urandom_range(0, 31);
                default: a = 32'hF000_0000 | ($urandom & 32'h0FFF_FFFF);
            endcase
            set_bus(2'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), a, 1'($urandom),
                    $urandom, $urandom_range(0, 3) != 0);
            bridge_ready = 1'($urandom);
            Prdata = $urandom;
            #2;
            exp_sel   = 3'(model_sel(Haddr, 64'h8000_0000, 64'h0400_0000, 3));
            exp_sel8  = 8'(model_sel(Haddr, 64'hF000_0000, 64'h0200_0000, 8));
            exp_valid = Hreadyin && Htrans[1] && (m_err == 0) &&
                        model_legal(Haddr, int'(Hsize), 64'h8000_0000, 64'h0400_0000, 3);
            exp_ready = (m_err == 2) ? 1'b0 : (m_err == 1) ? 1'b1 : bridge_ready;
            exp_resp  = (m_err != 0) ? 2'b01 : 2'b00;
            exp_rdata = (m_err != 0) ? 32'h0 : Prdata;
            n_checks++;
            if (valid !== exp_valid || tempselx !== exp_sel || tempselx8 !== exp_sel8) begin
                n_fail++; $display("[TB] FAIL rnd_decode[%0d]: addr=%h got v=%b s=%b s8=%h expected v=%b s=%b s8=%h",
                                   i, Haddr, valid, tempselx, tempselx8, exp_valid, exp_sel, exp_sel8);
            end
            n_checks++;
            if (Hreadyout !== exp_ready || Hresp !== exp_resp || Hrdata !== exp_rdata) begin
                n_fail++; $display("[TB] FAIL rnd_resp[%0d]: got ready=%b resp=%b rdata=%h expected %b/%b/%h",
                                   i, Hreadyout, Hresp, Hrdata, exp_ready, exp_resp, exp_rdata);
            end
            tick();
            n_checks++;
            if (Haddr1 !== m_a1 || Haddr2 !== m_a2 || Hwdata1 !== m_w1 || Hwdata2 !== m_w2 || Hwritereg !== m_wr) begin
                n_fail++; $display("[TB] FAIL rnd_pipe[%0d]: got %h %h %h %h %b expected %h %h %h %h %b",
                                   i, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, m_a1, m_a2, m_w1, m_w2, m_wr);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_mapped_write();
        test_unmapped();
        test_misaligned_oversize();
        test_wait_states();
        test_param8();
        test_reset_mid_err();
        bridge_ready = 1'b1;
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
